// File: rtl/cla4_seq_adder_ctrl.sv
// Sequential WIDTH-bit adder/subtractor: one 4-bit carry-lookahead slice is reused
// over WIDTH/4 cycles (LSB nibble first) between valid/ready operand and result ports.
module cla4_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [3:0]        p;
    logic [3:0]        g;
    logic [3:0]        s;
    logic              c1, c2, c3, c4;

    // Current nibble pair of the latched operands, selected by idx.
    always_comb begin
        a_sh = op_a >> {idx, 2'b00};
        b_sh = op_b >> {idx, 2'b00};
        p    = a_sh[3:0] ^ b_sh[3:0];
        g    = a_sh[3:0] & b_sh[3:0];
        c1   = g[0] | (p[0] & carry);
        c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry);
        s    = p ^ {c3, c2, c1, carry};
    end

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        carry <= sub;
                        idx   <= '0;
                        sum   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx, 2'b00} +: 4] <= s;
                    carry <= c4;
                    idx   <= idx + IDXW'(1);
                    if (idx == IDXW'(NIB - 1)) begin
                        cout      <= c4;
                        ovf       <= c3 ^ c4;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
